shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 168 ++++++++++++++++
 tb/tb_shift_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shifter sequencer: decodes the shifter operand of a
// data-processing instruction and iterates the shift STEP bits per cycle.
module shift_sequencer #(
   parameter int unsigned STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic [31:0] rm,
   input  logic        c_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        carry_out,
   output logic        s_bit
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 6;
   localparam logic [CW-1:0] STEP_N = CW'(STEP);

   typedef enum logic [1:0] {IDLE, DECODE, SHIFT, DONE} state_t;
   typedef enum logic [2:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR, SH_RRX} shtype_t;

   state_t          state_q, state_d;
   shtype_t         type_q, dec_type;
   logic [2:0]      op_q;
   logic [11:0]     lo_q;
   logic [DW-1:0]   rm_q;
   logic            cin_q;
   logic [CW-1:0]   rem_q, dec_n, k;
   logic [DW-1:0]   dec_val, stp_val;
   logic            dec_car, stp_car;
   logic            busy_d, done_d;
   logic [4:0]      amt;
   logic            unused_ir;

   // Instruction bits that never influence the shifter operand
   assign unused_ir = ^{ir[31:28], ir[24:21]};
   assign amt = lo_q[11:7];

   // Operand decode from the captured instruction: type, initial value, amount
   always_comb begin
      dec_type = SH_LSL;
      dec_val  = rm_q;
      dec_car  = cin_q;
      dec_n    = '0;
      if (op_q == 3'b001) begin
         dec_type = SH_ROR;
         dec_val  = {24'b0, lo_q[7:0]};
         dec_n    = {1'b0, lo_q[11:8], 1'b0};
      end else if ((op_q == 3'b000 && !lo_q[4]) || op_q == 3'b011) begin
         case (lo_q[6:5])
            2'b00: begin
               dec_type = SH_LSL;
               dec_n    = {1'b0, amt};
            end
            2'b01: begin
               dec_type = SH_LSR;
               dec_n    = (amt == 5'd0) ? CW'(32) : {1'b0, amt};
            end
            2'b10: begin
               dec_type = SH_ASR;
               dec_n    = (amt == 5'd0) ? CW'(32) : {1'b0, amt};
            end
            default: begin
               dec_type = (amt == 5'd0) ? SH_RRX : SH_ROR;
               dec_n    = (amt == 5'd0) ? CW'(1) : {1'b0, amt};
            end
         endcase
      end else if (op_q == 3'b010) begin
         dec_val = {20'b0, lo_q};
      end
   end

   // One shift step of k = min(STEP, remaining); carry is the last bit out
   always_comb begin
      k       = (rem_q < STEP_N) ? rem_q : STEP_N;
      stp_val = result;
      stp_car = carry_out;
      case (type_q)
         SH_LSL: begin
            stp_val = result << k;
            stp_car = result[5'(CW'(32) - k)];
         end
         SH_LSR: begin
            stp_val = result >> k;
            stp_car = result[5'(k - CW'(1))];
         end
         SH_ASR: begin
            stp_val = DW'($signed(result) >>> k);
            stp_car = result[5'(k - CW'(1))];
         end
         SH_ROR: begin
            stp_val = (result >> k) | (result << (CW'(32) - k));
            stp_car = result[5'(k - CW'(1))];
         end
         SH_RRX: begin
            stp_val = {carry_out, result[DW-1:1]};
            stp_car = result[0];
         end
         default: ;
      endcase
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = DECODE;
         DECODE:  state_d = (dec_n != '0) ? SHIFT : DONE;
         SHIFT:   if (rem_q <= STEP_N) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Capture, operand load, shift iteration and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         s_bit     <= 1'b0;
         op_q      <= '0;
         lo_q      <= '0;
         rm_q      <= '0;
         cin_q     <= 1'b0;
         rem_q     <= '0;
         type_q    <= SH_LSL;
      end else begin
         busy <= busy_d;
         done <= done_d;
         case (state_q)
            IDLE: if (start) begin
               op_q  <= ir[27:25];
               lo_q  <= ir[11:0];
               rm_q  <= rm;
               cin_q <= c_in;
               s_bit <= ir[20];
            end
            DECODE: begin
               result    <= dec_val;
               carry_out <= dec_car;
               rem_q     <= dec_n;
               type_q    <= dec_type;
            end
            SHIFT: begin
               result    <= stp_val;
               carry_out <= stp_car;
               rem_q     <= rem_q - k;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: STEP=1 and STEP=4 instances driven with identical stimulus.
module tb_shift_sequencer;

   logic        clk, rst_n, start, c_in;
   logic [31:0] ir, rm;
   logic        busy1, done1, car1, s1;
   logic        busy4, done4, car4, s4;
   logic [31:0] res1, res4;
   int          tests, errors;

   shift_sequencer #(.STEP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .rm(rm), .c_in(c_in),
      .busy(busy1), .done(done1), .result(res1), .carry_out(car1), .s_bit(s1));

   shift_sequencer #(.STEP(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .rm(rm), .c_in(c_in),
      .busy(busy4), .done(done4), .result(res4), .carry_out(car4), .s_bit(s4));

   // Clock
   always #5 clk = ~clk;

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One operation on both instances; l1/l4 are done cycles for STEP=1/4
   task automatic run_op(input string tag, input logic [31:0] i, input logic [31:0] r,
                         input logic c, input logic [31:0] er, input logic ec,
                         input int l1, input int l4);
      int d1, d4, p1, p4;
      d1 = -1; d4 = -1; p1 = 0; p4 = 0;
      ir = i; rm = r; c_in = c; start = 1'b1;
      for (int m = 1; m <= 40; m++) begin
         @(posedge clk); #1;
         if (m == 1) begin
            start = 1'b0;
            ir    = $urandom;
            rm    = $urandom;
            c_in  = ~c;
            chk({tag, "_busy"}, 32'(busy1), 32'd1);
         end
         if (done1) begin
            p1++;
            if (d1 < 0) begin
               d1 = m;
               chk({tag, "_res1"}, res1, er);
               chk({tag, "_car1"}, 32'(car1), 32'(ec));
               chk({tag, "_sbit1"}, 32'(s1), 32'(i[20]));
            end
         end
         if (done4) begin
            p4++;
            if (d4 < 0) begin
               d4 = m;
               chk({tag, "_res4"}, res4, er);
               chk({tag, "_car4"}, 32'(car4), 32'(ec));
            end
         end
         if (d1 >= 0 && d4 >= 0) break;
      end
      chk({tag, "_lat1"}, 32'(d1), 32'(l1));
      chk({tag, "_lat4"}, 32'(d4), 32'(l4));
      repeat (2) begin
         @(posedge clk); #1;
         if (done1) p1++;
         if (done4) p4++;
      end
      chk({tag, "_pulses"}, 32'(p1 + p4), 32'd2);
      chk({tag, "_hold1"}, res1, er);
      chk({tag, "_hold4"}, res4, er);
      chk({tag, "_idle"}, 32'({busy1, busy4}), 32'd0);
   endtask

   initial begin
      int p1, p4;
      tests = 0; errors = 0;
      clk = 1'b0; rst_n = 1'b0; start = 1'b0; ir = '0; rm = '0; c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'({busy1, busy4}), 32'd0);
      chk("rst_done", 32'({done1, done4}), 32'd0);
      chk("rst_res1", res1, 32'd0);
      chk("rst_res4", res4, 32'd0);
      chk("rst_car_s", 32'({car1, car4, s1, s4}), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Directed vectors (first one starts on the edge right after reset release)
      run_op("ror_imm",   32'h020004FF, 32'h0,        1'b0, 32'hFF000000, 1'b1, 10, 4);
      run_op("lsl4",      32'h00000200, 32'h8000000F, 1'b1, 32'h000000F0, 1'b0, 6,  3);
      run_op("asr4",      32'h00000240, 32'hF0000000, 1'b1, 32'hFF000000, 1'b0, 6,  3);
      run_op("lsr32",     32'h00000020, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 34, 10);
      run_op("rrx",       32'h00000060, 32'h00000003, 1'b1, 32'h80000001, 1'b1, 3,  3);
      run_op("imm12",     32'h05000ABC, 32'h12345678, 1'b1, 32'h00000ABC, 1'b1, 2,  2);
      run_op("lsl0_s",    32'h00100000, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 2,  2);
      run_op("asr32",     32'h00000040, 32'h80000001, 1'b0, 32'hFFFFFFFF, 1'b1, 34, 10);
      run_op("lsl31",     32'h00000F80, 32'h00000003, 1'b0, 32'h80000000, 1'b1, 33, 10);
      run_op("regshift",  32'h00000210, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 2,  2);
      run_op("ror_imm0",  32'h020000AB, 32'h0,        1'b1, 32'h000000AB, 1'b1, 2,  2);
      run_op("ror4",      32'h00000260, 32'h0000000F, 1'b0, 32'hF0000000, 1'b1, 6,  3);
      run_op("lsr4",      32'h00000220, 32'h0000001F, 1'b0, 32'h00000001, 1'b1, 6,  3);
      run_op("op011",     32'h06000200, 32'h00000001, 1'b1, 32'h00000010, 1'b0, 6,  3);
      run_op("other",     32'h08000200, 32'h00000055, 1'b0, 32'h00000055, 1'b0, 2,  2);

      // start held high: STEP=1 ignores it while busy, STEP=4 re-accepts once idle
      ir = 32'h00000200; rm = 32'h8000000F; c_in = 1'b0; start = 1'b1;
      p1 = 0; p4 = 0;
      for (int m = 1; m <= 12; m++) begin
         @(posedge clk); #1;
         if (m <= 6) chk("held_busy1", 32'(busy1), 32'd1);
         if (done1) p1++;
         if (done4) p4++;
         if (m == 7) chk("held_done4_again", 32'(done4), 32'd1);
         if (m == 6) start = 1'b0;
      end
      chk("held_pulses1", 32'(p1), 32'd1);
      chk("held_pulses4", 32'(p4), 32'd2);

      // Asynchronous reset in the middle of SHIFT
      ir = 32'h00000020; rm = 32'h80000000; c_in = 1'b0; start = 1'b1;
      for (int m = 1; m <= 5; m++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("mid_busy_pre", 32'({busy1, busy4}), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", 32'({busy1, busy4}), 32'd0);
      chk("mid_done", 32'({done1, done4}), 32'd0);
      chk("mid_res1", res1, 32'd0);
      chk("mid_res4", res4, 32'd0);
      chk("mid_car_s", 32'({car1, car4, s1, s4}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      p1 = 0;
      for (int m = 1; m <= 40; m++) begin
         @(posedge clk); #1;
         if (done1 || done4 || busy1 || busy4) p1++;
      end
      chk("mid_no_activity", 32'(p1), 32'd0);

      run_op("rrx_after", 32'h00000060, 32'h00000002, 1'b0, 32'h00000001, 1'b0, 3, 3);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
